// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the two-client SPI arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LAUNCH, XFER, HOLD)
//   cli_id_t    : client identifier, 0 = A2D interface, 1 = inertial sensor
//   SPI_FRAME_W : width of one SPI frame in bits
package spi_arb_pkg;

   localparam int SPI_FRAME_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      XFER   = 2'd2,
      HOLD   = 2'd3
   } arb_state_t;

   typedef logic cli_id_t;

endpackage

// File: rtl/spi_arb_wdog.sv
// spi_arb_wdog: HOLD-state watchdog for the SPI arbiter.
// Counts cycles a locked owner sits in HOLD without requesting and flags
// expiry on the cycle the count reaches TIMEOUT_CYC-1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (outside HOLD or on an owner request)
//   count      : advance the count this cycle
//   expired    : count has reached its limit while counting
import spi_arb_pkg::*;

module spi_arb_wdog #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   // Saturate at the limit so a held-off release cannot wrap the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = count && (cnt == LIMIT);

endmodule

// File: rtl/spi_arb.sv
// spi_arb: shares one SPI monarch between two clients (A2D and inertial
// sensor). Frames are granted one at a time, round-robin between clients,
// and a client may lock the bus across consecutive frames.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cliN_vld/lock/wt_data      : client N frame request, lock-after, frame
//   cliN_ack                   : combinational accept pulse
//   cliN_done, cliN_rd_data    : frame complete pulse and held read data
//   spi_wrt, spi_wt_data       : start pulse and frame to the monarch
//   spi_done, spi_rd_data      : monarch completion and read data
//   owner                      : current or last owner
//   arb_timeout                : forced-release pulse
// Optional feature: define SPI_ARB_TIMEOUT_EN to release a locked owner that
// idles in HOLD for TIMEOUT_CYC cycles; otherwise arb_timeout is tied 0.
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cli0_vld,
   input  logic                   cli0_lock,
   input  logic [SPI_FRAME_W-1:0] cli0_wt_data,
   input  logic                   cli1_vld,
   input  logic                   cli1_lock,
   input  logic [SPI_FRAME_W-1:0] cli1_wt_data,
   output logic                   cli0_ack,
   output logic                   cli1_ack,
   output logic                   cli0_done,
   output logic                   cli1_done,
   output logic [SPI_FRAME_W-1:0] cli0_rd_data,
   output logic [SPI_FRAME_W-1:0] cli1_rd_data,
   output logic                   spi_wrt,
   output logic [SPI_FRAME_W-1:0] spi_wt_data,
   input  logic                   spi_done,
   input  logic [SPI_FRAME_W-1:0] spi_rd_data,
   output logic                   owner,
   output logic                   arb_timeout
);

   arb_state_t             state;
   cli_id_t                owner_q;
   cli_id_t                rr_ptr;
   logic                   lock_q;
   logic                   wrt_q;
   logic                   done0_q;
   logic                   done1_q;
   logic                   timeout_q;
   logic [SPI_FRAME_W-1:0] rd0_q;
   logic [SPI_FRAME_W-1:0] rd1_q;
   logic [SPI_FRAME_W-1:0] wt_data_q;

   logic                   grant;
   cli_id_t                grant_id;
   logic [SPI_FRAME_W-1:0] grant_data;
   logic                   grant_lock;
   logic                   owner_vld;
   logic                   owner_lock;
   logic                   hold_expired;

   assign owner_vld  = owner_q ? cli1_vld  : cli0_vld;
   assign owner_lock = owner_q ? cli1_lock : cli0_lock;
   assign grant_data = grant_id ? cli1_wt_data : cli0_wt_data;
   assign grant_lock = grant_id ? cli1_lock    : cli0_lock;

   // The ack is combinational so a request is accepted in the cycle it is
   // seen; it is masked during reset so every output reads 0 in reset.
   always_comb begin
      grant    = 1'b0;
      grant_id = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (cli0_vld && cli1_vld) begin
                  grant    = 1'b1;
                  grant_id = rr_ptr;
               end else if (cli0_vld) begin
                  grant    = 1'b1;
                  grant_id = 1'b0;
               end else if (cli1_vld) begin
                  grant    = 1'b1;
                  grant_id = 1'b1;
               end
            end
            HOLD: begin
               if (owner_vld) begin
                  grant    = 1'b1;
                  grant_id = owner_q;
               end
            end
            default: begin
               grant    = 1'b0;
               grant_id = 1'b0;
            end
         endcase
      end
   end

   assign cli0_ack = grant && (grant_id == 1'b0);
   assign cli1_ack = grant && (grant_id == 1'b1);

   // A grant from IDLE or HOLD takes the same path into LAUNCH; HOLD only
   // ever grants the current owner, so owner_q is unchanged there. Every
   // release out of ownership hands the round-robin pointer to the other
   // client.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner_q   <= 1'b0;
         rr_ptr    <= 1'b0;
         lock_q    <= 1'b0;
         wrt_q     <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         timeout_q <= 1'b0;
         rd0_q     <= '0;
         rd1_q     <= '0;
         wt_data_q <= '0;
      end else begin
         wrt_q     <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         timeout_q <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               if (grant) begin
                  owner_q   <= grant_id;
                  wt_data_q <= grant_data;
                  lock_q    <= grant_lock;
                  wrt_q     <= 1'b1;
                  state     <= LAUNCH;
               end else if (state == HOLD) begin
                  if (!owner_lock) begin
                     rr_ptr <= ~owner_q;
                     state  <= IDLE;
                  end else if (hold_expired) begin
                     rr_ptr    <= ~owner_q;
                     timeout_q <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            LAUNCH: begin
               state <= XFER;
            end
            XFER: begin
               if (spi_done) begin
                  if (owner_q) begin
                     rd1_q   <= spi_rd_data;
                     done1_q <= 1'b1;
                  end else begin
                     rd0_q   <= spi_rd_data;
                     done0_q <= 1'b1;
                  end
                  if (lock_q) begin
                     state <= HOLD;
                  end else begin
                     rr_ptr <= ~owner_q;
                     state  <= IDLE;
                  end
               end
            end
         endcase
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   logic wdog_clear;
   logic wdog_count;

   assign wdog_clear = (state != HOLD) || owner_vld;
   assign wdog_count = (state == HOLD) && !owner_vld;

   spi_arb_wdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (wdog_clear),
      .count  (wdog_count),
      .expired(hold_expired)
   );

   assign arb_timeout = timeout_q;
`else
   logic unused_timeout;

   assign hold_expired   = 1'b0;
   assign arb_timeout    = 1'b0;
   assign unused_timeout = ^{TIMEOUT_CYC, timeout_q};
`endif

   assign cli0_done    = done0_q;
   assign cli1_done    = done1_q;
   assign cli0_rd_data = rd0_q;
   assign cli1_rd_data = rd1_q;
   assign spi_wrt      = wrt_q;
   assign spi_wt_data  = wt_data_q;
   assign owner        = owner_q;

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: self-checking bench for spi_arb. A behavioural SPI monarch
// answers each spi_wrt after a random frame length; the expected winner and
// read data come from a small model of the arbitration rules (favoured
// client, last read word per client).
module tb_spi_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cli0_vld, cli0_lock, cli1_vld, cli1_lock;
   logic [15:0] cli0_wt_data, cli1_wt_data;
   logic        cli0_ack, cli1_ack, cli0_done, cli1_done;
   logic [15:0] cli0_rd_data, cli1_rd_data;
   logic        spi_wrt;
   logic [15:0] spi_wt_data;
   logic        spi_done;
   logic [15:0] spi_rd_data;
   logic        owner, arb_timeout;

   int n_compared = 0;
   int n_mismatched = 0;
   int ack_count = 0;
   int wrt_count = 0;

   // reference model state
   bit          model_rr;
   logic [15:0] model_rd [2];

   // monarch model
   logic [15:0] mon_resp;
   int          mon_len;
   logic [15:0] mon_cur;
   int          mon_left;
   bit          mon_busy;

   spi_arb #(.TIMEOUT_CYC(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cli0_vld    (cli0_vld),
      .cli0_lock   (cli0_lock),
      .cli0_wt_data(cli0_wt_data),
      .cli1_vld    (cli1_vld),
      .cli1_lock   (cli1_lock),
      .cli1_wt_data(cli1_wt_data),
      .cli0_ack    (cli0_ack),
      .cli1_ack    (cli1_ack),
      .cli0_done   (cli0_done),
      .cli1_done   (cli1_done),
      .cli0_rd_data(cli0_rd_data),
      .cli1_rd_data(cli1_rd_data),
      .spi_wrt     (spi_wrt),
      .spi_wt_data (spi_wt_data),
      .spi_done    (spi_done),
      .spi_rd_data (spi_rd_data),
      .owner       (owner),
      .arb_timeout (arb_timeout)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive phase is 2 time units after the rising edge, sampling 1 later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input bit cli, input bit vld, input logic [15:0] data,
                                 input bit lock);
      if (cli) begin
         cli1_vld = vld; cli1_wt_data = data; cli1_lock = lock;
      end else begin
         cli0_vld = vld; cli0_wt_data = data; cli0_lock = lock;
      end
   endtask

   function automatic bit model_winner(input bit v0, input bit v1);
      if (v0 && v1) return model_rr;
      return v1;
   endfunction

   task automatic check_all_zero(input string tag);
      check_output({tag, "_ack"}, 32'({cli1_ack, cli0_ack}), 0);
      check_output({tag, "_done"}, 32'({cli1_done, cli0_done}), 0);
      check_output({tag, "_rd0"}, 32'(cli0_rd_data), 0);
      check_output({tag, "_rd1"}, 32'(cli1_rd_data), 0);
      check_output({tag, "_wrt"}, 32'(spi_wrt), 0);
      check_output({tag, "_wt_data"}, 32'(spi_wt_data), 0);
      check_output({tag, "_owner"}, 32'(owner), 0);
      check_output({tag, "_timeout"}, 32'(arb_timeout), 0);
   endtask

   task automatic wait_ack(input bit cli, input int budget);
      int n = 0;
      #1;
      while (!(cli0_ack || cli1_ack) && n < budget) begin
         tick(); #1; n++;
      end
      check_output("ack_client", 32'({cli1_ack, cli0_ack}), cli ? 2 : 1);
      if (cli0_ack || cli1_ack) ack_count++;
   endtask

   task automatic check_launch(input bit cli, input logic [15:0] data);
      tick();
      if (cli) cli1_vld = 1'b0; else cli0_vld = 1'b0;
      #1;
      check_output("launch_wrt", 32'(spi_wrt), 1);
      check_output("launch_wt_data", 32'(spi_wt_data), 32'(data));
      check_output("launch_owner", 32'(owner), 32'(cli));
      check_output("launch_no_ack", 32'({cli1_ack, cli0_ack}), 0);
      tick(); #1;
      check_output("wrt_one_cycle", 32'(spi_wrt), 0);
   endtask

   task automatic wait_done(input bit cli, input logic [15:0] resp, input int budget);
      int n = 0;
      while (!(cli0_done || cli1_done) && n < budget) begin
         tick(); #1; n++;
      end
      check_output("done_client", 32'({cli1_done, cli0_done}), cli ? 2 : 1);
      model_rd[cli] = resp;
      check_output("rd_data0", 32'(cli0_rd_data), 32'(model_rd[0]));
      check_output("rd_data1", 32'(cli1_rd_data), 32'(model_rd[1]));
   endtask

   // Behavioural monarch: answers spi_wrt with spi_done mon_len cycles later.
   initial begin : monarch
      spi_done = 1'b0; spi_rd_data = '0; mon_busy = 1'b0; mon_left = 0; mon_cur = '0;
      forever begin
         @(posedge clk);
         #1;
         spi_done = 1'b0;
         if (!rst_n) begin
            mon_busy = 1'b0;
         end else if (spi_wrt) begin
            check_output("wrt_while_busy", 32'(mon_busy), 0);
            wrt_count++;
            mon_busy = 1'b1;
            mon_left = mon_len;
            mon_cur  = mon_resp;
         end else if (mon_busy) begin
            if (mon_left <= 1) begin
               spi_done    = 1'b1;
               spi_rd_data = mon_cur;
               mon_busy    = 1'b0;
            end else begin
               mon_left--;
            end
         end
      end
   end

   initial begin : guard
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin : stimulus
      logic [15:0] d0, d1, d2, resp, resp2;
      logic [1:0]  v;
      bit          w;
      int          n, n_ack, n_to;

      cli0_vld = 0; cli0_lock = 0; cli0_wt_data = '0;
      cli1_vld = 0; cli1_lock = 0; cli1_wt_data = '0;
      mon_resp = '0; mon_len = 2;
      model_rr = 1'b0; model_rd[0] = '0; model_rd[1] = '0;

      // reset state
      repeat (3) @(posedge clk);
      #3;
      check_all_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // single client-1 request
      $display("[TB] single request from client 1");
      mon_resp = 16'($urandom); mon_len = $urandom_range(1, 4);
      resp = mon_resp;
      apply_stimulus(1, 1, 16'h2800, 0);
      wait_ack(1, 0);
      check_launch(1, 16'h2800);
      wait_done(1, resp, 20);
      model_rr = 1'b0;

      // simultaneous unlocked requests
      $display("[TB] simultaneous requests");
      d0 = 16'($urandom); d1 = 16'($urandom);
      tick();
      mon_resp = 16'h0ABC; mon_len = $urandom_range(1, 4);
      apply_stimulus(0, 1, d0, 0);
      apply_stimulus(1, 1, d1, 0);
      w = model_winner(1, 1);
      wait_ack(w, 0);
      check_launch(0, d0);
      mon_resp = 16'h0123; mon_len = $urandom_range(1, 4);
      wait_done(0, 16'h0ABC, 20);
      model_rr = 1'b1;
      wait_ack(1, 0);
      check_launch(1, d1);
      wait_done(1, 16'h0123, 20);
      model_rr = 1'b0;

      // client 0 locks across two frames while client 1 waits
      $display("[TB] locked client 0 with client 1 pending");
      d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
      tick();
      resp = 16'($urandom); mon_resp = resp; mon_len = $urandom_range(1, 4);
      apply_stimulus(0, 1, d0, 1);
      apply_stimulus(1, 1, d1, 0);
      wait_ack(model_winner(1, 1), 0);
      check_launch(0, d0);
      wait_done(0, resp, 20);
      for (int i = 0; i < 4; i++) begin
         check_output("hold_blocks_other", 32'({cli1_ack, cli0_ack}), 0);
         tick(); #1;
      end
      mon_resp = 16'h0FFF; mon_len = $urandom_range(1, 4);
      apply_stimulus(0, 1, d2, 0);
      wait_ack(0, 0);
      check_launch(0, d2);
      resp2 = 16'($urandom); mon_resp = resp2;
      wait_done(0, 16'h0FFF, 20);
      model_rr = 1'b1;
      wait_ack(1, 0);
      check_launch(1, d1);
      wait_done(1, resp2, 20);
      model_rr = 1'b0;

      // locked owner idles in HOLD with the other client pending
      $display("[TB] locked idle owner");
      d0 = 16'($urandom); d1 = 16'($urandom);
      tick();
      resp = 16'($urandom); mon_resp = resp; mon_len = $urandom_range(1, 4);
      apply_stimulus(1, 1, d1, 1);
      wait_ack(1, 0);
      check_launch(1, d1);
      wait_done(1, resp, 20);
      resp2 = 16'($urandom); mon_resp = resp2;
      apply_stimulus(0, 1, d0, 0);
`ifdef SPI_ARB_TIMEOUT_EN
      n = 0;
      while (!arb_timeout && n < 20) begin
         tick(); #1; n++;
      end
      check_output("timeout_cycles", 32'(n), 8);
      check_output("timeout_pulse", 32'(arb_timeout), 1);
      wait_ack(0, 0);
      cli1_lock = 1'b0;
`else
      n_ack = 0; n_to = 0;
      for (int i = 0; i < 100; i++) begin
         tick(); #1;
         if (cli0_ack) n_ack++;
         if (arb_timeout) n_to++;
      end
      check_output("hold_persist_ack", 32'(n_ack), 0);
      check_output("hold_persist_timeout", 32'(n_to), 0);
      check_output("hold_persist_owner", 32'(owner), 1);
      tick();
      cli1_lock = 1'b0;
      #1;
      check_output("release_not_same_cycle", 32'(cli0_ack), 0);
      wait_ack(0, 1);
`endif
      model_rr = 1'b0;
      check_launch(0, d0);
      wait_done(0, resp2, 20);
      model_rr = 1'b1;

      // random unlocked rounds; losers withdraw after the winner launches
      $display("[TB] random unlocked rounds");
      for (int i = 0; i < 8; i++) begin
         v  = 2'($urandom_range(1, 3));
         d0 = 16'($urandom); d1 = 16'($urandom);
         resp = 16'($urandom);
         tick();
         mon_resp = resp; mon_len = $urandom_range(1, 4);
         apply_stimulus(0, v[0], d0, 0);
         apply_stimulus(1, v[1], d1, 0);
         w = model_winner(v[0], v[1]);
         wait_ack(w, 0);
         check_launch(w, w ? d1 : d0);
         cli0_vld = 1'b0; cli1_vld = 1'b0;
         wait_done(w, resp, 20);
         model_rr = ~w;
      end

      // reset during XFER
      $display("[TB] reset mid-transfer");
      d1 = 16'($urandom);
      tick();
      mon_resp = 16'($urandom); mon_len = 6;
      apply_stimulus(1, 1, d1, 0);
      wait_ack(1, 0);
      check_launch(1, d1);
      tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      model_rr = 1'b0; model_rd[0] = '0; model_rd[1] = '0;
      tick(); tick();
      rst_n = 1'b1;
      d0 = 16'($urandom); d1 = 16'($urandom);
      tick();
      resp = 16'($urandom); mon_resp = resp; mon_len = $urandom_range(1, 4);
      apply_stimulus(0, 1, d0, 0);
      apply_stimulus(1, 1, d1, 0);
      wait_ack(model_winner(1, 1), 0);
      check_launch(0, d0);
      cli1_vld = 1'b0;
      wait_done(0, resp, 20);

      tick(); tick();
      check_output("wrt_vs_ack", 32'(wrt_count), 32'(ack_count));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
